// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded scheduler sharing the async FIFO write port (wclk domain).
// Optional macro FIFO_ARB_PRIORITY_EN makes requester 0 a high-priority requester.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDWIDTH  = 2,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 4,
  parameter int CNTWIDTH = 2
) (
  input  logic                     wclk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     full,
  output logic                     push,
  output logic [DWIDTH-1:0]        wdata,
  output logic                     busy,
  output logic [IDWIDTH-1:0]       gnt_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [IDWIDTH-1:0]  gnt_nxt;
  logic [IDWIDTH-1:0]  last_gnt, last_gnt_nxt;
  logic [CNTWIDTH-1:0] beat_cnt, beat_cnt_nxt;
  logic [IDWIDTH-1:0]  pick;
  logic                pick_vld;

  // Rotating scan: the requester after last_gnt gets first look, last_gnt itself gets last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_gnt) + k) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick     = IDWIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
`ifdef FIFO_ARB_PRIORITY_EN
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt_id   <= '0;
      last_gnt <= IDWIDTH'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_id   <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_id;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    push         = 1'b0;
    ack          = '0;
    wdata        = '0;
    busy         = (state == BURST);

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt      = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        push = req[gnt_id] & ~full;
        if (push) begin
          ack[gnt_id] = 1'b1;
          wdata       = req_data[int'(gnt_id)*DWIDTH +: DWIDTH];
        end
        // A dropped request and a final beat both end the burst through one exit path.
        if (!req[gnt_id] || (push && beat_cnt == CNTWIDTH'(MAXBURST - 1))) begin
          state_nxt = IDLE;
`ifdef FIFO_ARB_PRIORITY_EN
          if (gnt_id != '0) last_gnt_nxt = gnt_id;
`else
          last_gnt_nxt = gnt_id;
`endif
        end
        if (push) beat_cnt_nxt = beat_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter against a beat-level scheduling model.
module tb_fifo_wr_arbiter;
  localparam int NREQ     = 4;
  localparam int IDWIDTH  = 2;
  localparam int DWIDTH   = 8;
  localparam int MAXBURST = 4;
  localparam int CNTWIDTH = 2;

  logic                   wclk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   full;
  logic                   push;
  logic [DWIDTH-1:0]      wdata;
  logic                   busy;
  logic [IDWIDTH-1:0]     gnt_id;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .IDWIDTH(IDWIDTH), .DWIDTH(DWIDTH),
    .MAXBURST(MAXBURST), .CNTWIDTH(CNTWIDTH)
  ) dut (
    .wclk(wclk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .full(full), .push(push), .wdata(wdata), .busy(busy), .gnt_id(gnt_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Requester side: beats still owed and the data word currently presented.
  int                pend[NREQ];
  logic [DWIDTH-1:0] dat[NREQ];
  int                ack_cnt[NREQ];
  bit                rand_data;
  logic [DWIDTH-1:0] cap[$];

  // Scheduler model: who owns the port (-1 = nobody), beats granted so far, fairness pointer.
  int m_owner, m_gnt, m_last, m_beats;

  task automatic model_reset();
    m_owner = -1;
    m_gnt   = 0;
    m_last  = NREQ - 1;
    m_beats = 0;
  endtask

  function automatic int next_owner();
`ifdef FIFO_ARB_PRIORITY_EN
    if (pend[0] > 0) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (pend[idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic end_burst();
`ifdef FIFO_ARB_PRIORITY_EN
    if (m_owner != 0) m_last = m_owner;
`else
    m_last = m_owner;
`endif
    m_owner = -1;
  endtask

  task automatic drive(input bit f);
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (pend[i] > 0);
      req_data[i*DWIDTH +: DWIDTH] = dat[i];
    end
    full = f;
  endtask

  task automatic check_update();
    bit                e_busy, e_push;
    logic [NREQ-1:0]   e_ack;
    logic [DWIDTH-1:0] e_wdata;
    int                o, p;
    o       = m_owner;
    e_busy  = (o >= 0);
    e_push  = e_busy && (pend[o] > 0) && !full;
    e_ack   = '0;
    e_wdata = '0;
    if (e_push) begin
      e_ack[o] = 1'b1;
      e_wdata  = dat[o];
    end
    chk("push",   32'(push),   32'(e_push));
    chk("ack",    32'(ack),    32'(e_ack));
    chk("wdata",  32'(wdata),  32'(e_wdata));
    chk("busy",   32'(busy),   32'(e_busy));
    chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
    if (push) cap.push_back(wdata);
    if (!e_busy) begin
      p = next_owner();
      if (p >= 0) begin
        m_owner = p;
        m_gnt   = p;
        m_beats = 0;
      end
    end else if (pend[o] == 0) begin
      end_burst();
    end else if (e_push) begin
      m_beats++;
      if (m_beats == MAXBURST) end_burst();
    end
    if (e_push) begin
      pend[o]--;
      ack_cnt[o]++;
      dat[o] = rand_data ? DWIDTH'($urandom) : dat[o] + 1'b1;
    end
  endtask

  task automatic step(input bit f);
    drive(f);
    #1;
    check_update();
    @(negedge wclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_push"},  32'(push),   32'd0);
    chk({tag, "_ack"},   32'(ack),    32'd0);
    chk({tag, "_busy"},  32'(busy),   32'd0);
    chk({tag, "_gnt"},   32'(gnt_id), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i]    = 0;
      ack_cnt[i] = 0;
    end
    cap.delete();
    @(negedge wclk);
    reset = 1'b0;
  endtask

  logic [DWIDTH-1:0] exp2[8];
  bit dropped;

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    full      = 1'b0;
    rand_data = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0;
      dat[i]  = '0;
    end
    model_reset();
    @(negedge wclk);

    // Single requester, 6 beats: burst of MAXBURST, re-arbitration, remaining 2.
    do_reset();
    pend[0] = 6;
    dat[0]  = 8'hA0;
    repeat (10) step(1'b0);
    chk("t1_count", 32'(cap.size()), 32'd6);
    chk("t1_first", 32'(cap.size() > 0 ? cap[0] : 8'hxx), 32'h0A0);
    chk("t1_last",  32'(cap.size() > 5 ? cap[5] : 8'hxx), 32'h0A5);

    // All four requesting 2 beats each: served 0,1,2,3 in order.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 2;
      dat[i]  = DWIDTH'(8'h10 * (i + 1));
    end
    exp2 = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
    repeat (20) step(1'b0);
    chk("t2_count", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_order%0d", i), 32'(cap.size() > i ? cap[i] : 8'hxx), 32'(exp2[i]));

    // Requester 2 stalled by full for 5 cycles after its first beat.
    do_reset();
    pend[2] = 4;
    dat[2]  = 8'hC0;
    step(1'b0);
    step(1'b0);
    repeat (5) step(1'b1);
    repeat (6) step(1'b0);
    chk("t3_count", 32'(cap.size()), 32'd4);
    chk("t3_gnt",   32'(gnt_id),     32'd2);

    // Requester 1 abandons after 2 beats; requester 3 takes over.
    do_reset();
    pend[1] = 5;
    dat[1]  = 8'h20;
    pend[3] = 2;
    dat[3]  = 8'h30;
    dropped = 1'b0;
    repeat (12) begin
      if (!dropped && ack_cnt[1] == 2) begin
        pend[1] = 0;
        dropped = 1'b1;
      end
      step(1'b0);
    end
    chk("t4_count", 32'(cap.size()), 32'd4);
    chk("t4_third", 32'(cap.size() > 2 ? cap[2] : 8'hxx), 32'h030);
    chk("t4_gnt",   32'(gnt_id), 32'd3);

    // Reset asserted mid-beat: outputs drop at once, arbitration restarts from 0.
    do_reset();
    pend[2] = 6;
    dat[2]  = 8'h50;
    step(1'b0);
    step(1'b0);
    drive(1'b0);
    #1;
    chk("t5_push_pre", 32'(push), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5");
    model_reset();
    pend[0] = 2;
    dat[0]  = 8'h60;
    @(negedge wclk);
    reset = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("t5_regnt", 32'(gnt_id), 32'd0);
    repeat (12) step(1'b0);

    // Random traffic, random full, random abandonment.
    do_reset();
    rand_data = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] == 0 && ($urandom % 4) == 0) begin
          pend[i] = int'($urandom_range(1, 7));
          dat[i]  = DWIDTH'($urandom);
        end else if (pend[i] > 0 && ($urandom % 20) == 0) begin
          pend[i] = 0;
        end
      end
      step(($urandom % 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
